// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if #(
    parameter int ADDR_W = 12
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: lw/sw over a req/ack bus with timeout, stall generation and MEM_WB registers.
// Optional one-entry store-to-load bypass enabled by defining MEM_STORE_BYPASS_EN.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 12
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 valid_in,
    input  logic [31:0]          ALUOutM,
    input  logic [31:0]          WriteDataM,
    input  logic                 MemReadM,
    input  logic                 MemWriteM,
    input  logic                 RegWriteM,
    input  logic [4:0]           WriteRegM,
    mem_access_stage_if.master   mem,
    output logic                 STALL_M,
    output logic                 valid_out,
    output logic [31:0]          ALUOutW,
    output logic [31:0]          ReadDataW,
    output logic [4:0]           WriteRegW,
    output logic                 RegWriteW,
    output logic                 MemtoRegW,
    output logic                 align_err,
    output logic                 bus_err
);
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lat_alu_q, lat_alu_d;
    logic [4:0]        lat_wreg_q, lat_wreg_d;
    logic              lat_rw_q, lat_rw_d, lat_rd_q, lat_rd_d;
    logic              valid_q, valid_d;
    logic [31:0]       aluw_q, aluw_d, rdw_q, rdw_d;
    logic [4:0]        wregw_q, wregw_d;
    logic              rww_q, rww_d, m2r_q, m2r_d;
    logic              aerr_q, aerr_d, berr_q, berr_d;

    logic              memop, misaligned, is_load, byp_hit;
    logic [ADDR_W-1:0] word_addr;

    assign memop      = valid_in & (MemReadM | MemWriteM);
    assign misaligned = memop & (ALUOutM[1:0] != 2'b00);
    assign is_load    = MemReadM & ~MemWriteM;
    assign word_addr  = ALUOutM[ADDR_W+1:2];

`ifdef MEM_STORE_BYPASS_EN
    logic              sb_v_q, sb_v_d;
    logic [ADDR_W-1:0] sb_addr_q, sb_addr_d;
    logic [31:0]       sb_data_q, sb_data_d;

    assign byp_hit = memop & ~misaligned & is_load & sb_v_q & (sb_addr_q == word_addr);
`else
    assign byp_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lat_alu_d  = lat_alu_q;
        lat_wreg_d = lat_wreg_q;
        lat_rw_d   = lat_rw_q;
        lat_rd_d   = lat_rd_q;
        valid_d    = valid_q;
        aluw_d     = aluw_q;
        rdw_d      = rdw_q;
        wregw_d    = wregw_q;
        rww_d      = rww_q;
        m2r_d      = m2r_q;
        aerr_d     = aerr_q;
        berr_d     = berr_q;
        STALL_M    = 1'b0;
`ifdef MEM_STORE_BYPASS_EN
        sb_v_d     = sb_v_q;
        sb_addr_d  = sb_addr_q;
        sb_data_d  = sb_data_q;
`endif
        case (state_q)
            S_IDLE: begin
                STALL_M = memop & ~misaligned & ~byp_hit;
                if (misaligned) begin
                    valid_d = 1'b1;
                    aluw_d  = ALUOutM;
                    wregw_d = WriteRegM;
                    rww_d   = 1'b0;
                    m2r_d   = 1'b0;
                    aerr_d  = 1'b1;
                end else if (byp_hit) begin
                    valid_d = 1'b1;
                    aluw_d  = ALUOutM;
                    wregw_d = WriteRegM;
                    rww_d   = RegWriteM;
                    m2r_d   = 1'b1;
`ifdef MEM_STORE_BYPASS_EN
                    rdw_d   = sb_data_q;
`endif
                end else if (memop) begin
                    req_d      = 1'b1;
                    we_d       = MemWriteM;
                    addr_d     = word_addr;
                    wdata_d    = WriteDataM;
                    lat_alu_d  = ALUOutM;
                    lat_wreg_d = WriteRegM;
                    lat_rw_d   = RegWriteM;
                    lat_rd_d   = is_load;
                    valid_d    = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_BUSY;
                end else begin
                    valid_d = valid_in;
                    aluw_d  = ALUOutM;
                    wregw_d = WriteRegM;
                    rww_d   = RegWriteM;
                    m2r_d   = 1'b0;
                end
            end
            S_BUSY: begin
                STALL_M = ~mem.mem_ack;
                valid_d = 1'b0;
                if (mem.mem_ack) begin
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    aluw_d  = lat_alu_q;
                    wregw_d = lat_wreg_q;
                    rww_d   = lat_rw_q;
                    m2r_d   = lat_rd_q;
                    if (lat_rd_q) rdw_d = mem.mem_rdata;
`ifdef MEM_STORE_BYPASS_EN
                    if (we_q) begin
                        sb_v_d    = 1'b1;
                        sb_addr_d = addr_q;
                        sb_data_d = wdata_q;
                    end
`endif
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    valid_d = 1'b1;
                    rww_d   = 1'b0;
                    m2r_d   = 1'b0;
`ifdef MEM_STORE_BYPASS_EN
                    sb_v_d  = 1'b0;
`endif
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_alu_q  <= '0;
            lat_wreg_q <= '0;
            lat_rw_q   <= 1'b0;
            lat_rd_q   <= 1'b0;
            valid_q    <= 1'b0;
            aluw_q     <= '0;
            rdw_q      <= '0;
            wregw_q    <= '0;
            rww_q      <= 1'b0;
            m2r_q      <= 1'b0;
            aerr_q     <= 1'b0;
            berr_q     <= 1'b0;
`ifdef MEM_STORE_BYPASS_EN
            sb_v_q     <= 1'b0;
            sb_addr_q  <= '0;
            sb_data_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lat_alu_q  <= lat_alu_d;
            lat_wreg_q <= lat_wreg_d;
            lat_rw_q   <= lat_rw_d;
            lat_rd_q   <= lat_rd_d;
            valid_q    <= valid_d;
            aluw_q     <= aluw_d;
            rdw_q      <= rdw_d;
            wregw_q    <= wregw_d;
            rww_q      <= rww_d;
            m2r_q      <= m2r_d;
            aerr_q     <= aerr_d;
            berr_q     <= berr_d;
`ifdef MEM_STORE_BYPASS_EN
            sb_v_q     <= sb_v_d;
            sb_addr_q  <= sb_addr_d;
            sb_data_q  <= sb_data_d;
`endif
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign valid_out     = valid_q;
    assign ALUOutW       = aluw_q;
    assign ReadDataW     = rdw_q;
    assign WriteRegW     = wregw_q;
    assign RegWriteW     = rww_q;
    assign MemtoRegW     = m2r_q;
    assign align_err     = aerr_q;
    assign bus_err       = berr_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, sw/lw handshakes, misalignment,
// timeout (TIMEOUT_CYCLES=4), reset during an access and the store-bypass path.
module tb_mem_access_stage;
`ifdef MEM_STORE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        RESET;
    logic        valid_in, MemReadM, MemWriteM, RegWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;
    logic        STALL_M, valid_out, RegWriteW, MemtoRegW, align_err, bus_err;
    logic [31:0] ALUOutW, ReadDataW;
    logic [4:0]  WriteRegW;
    int          n_cmp = 0;
    int          n_err = 0;

    mem_access_stage_if #(.ADDR_W(12)) bus ();

    mem_access_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(12)) dut (
        .CLOCK      (clk),
        .RESET      (RESET),
        .valid_in   (valid_in),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .RegWriteM  (RegWriteM),
        .WriteRegM  (WriteRegM),
        .mem        (bus.master),
        .STALL_M    (STALL_M),
        .valid_out  (valid_out),
        .ALUOutW    (ALUOutW),
        .ReadDataW  (ReadDataW),
        .WriteRegW  (WriteRegW),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .align_err  (align_err),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic rw,
                         input logic [4:0] wreg, input logic [31:0] alu, input logic [31:0] wd);
        valid_in   = v;
        MemReadM   = rd;
        MemWriteM  = wr;
        RegWriteM  = rw;
        WriteRegM  = wreg;
        ALUOutM    = alu;
        WriteDataM = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    initial begin
        RESET = 1'b1;
        idle();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        tick();
        tick();
        check("rst_req",    {31'b0, bus.mem_req}, 32'd0);
        check("rst_we",     {31'b0, bus.mem_we}, 32'd0);
        check("rst_addr",   {20'b0, bus.mem_addr}, 32'd0);
        check("rst_wdata",  bus.mem_wdata, 32'd0);
        check("rst_vout",   {31'b0, valid_out}, 32'd0);
        check("rst_aluw",   ALUOutW, 32'd0);
        check("rst_rdw",    ReadDataW, 32'd0);
        check("rst_flags",  {26'b0, WriteRegW, RegWriteW}, 32'd0);
        check("rst_errs",   {29'b0, MemtoRegW, align_err, bus_err}, 32'd0);
        check("rst_stall",  {31'b0, STALL_M}, 32'd0);
        RESET = 1'b0;

        // add: one-cycle pass-through
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 32'h5, 32'h0);
        #1 check("add_stall", {31'b0, STALL_M}, 32'd0);
        tick();
        idle();
        check("add_vout", {31'b0, valid_out}, 32'd1);
        check("add_aluw", ALUOutW, 32'h5);
        check("add_wreg", {27'b0, WriteRegW}, 32'd8);
        check("add_rw",   {31'b0, RegWriteW}, 32'd1);
        check("add_m2r",  {31'b0, MemtoRegW}, 32'd0);
        check("add_req",  {31'b0, bus.mem_req}, 32'd0);
        tick();
        check("add_vout_drop", {31'b0, valid_out}, 32'd0);
        check("add_req2", {31'b0, bus.mem_req}, 32'd0);

        // sw 0x10 <- CAFE, ack in the third busy cycle; inputs changed while busy
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h10, 32'hCAFE);
        #1 check("sw_stall_idle", {31'b0, STALL_M}, 32'd1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'hFF0, 32'h1111);
        for (int i = 0; i < 3; i++) begin
            check("sw_req",   {31'b0, bus.mem_req}, 32'd1);
            check("sw_we",    {31'b0, bus.mem_we}, 32'd1);
            check("sw_addr",  {20'b0, bus.mem_addr}, 32'd4);
            check("sw_wdata", bus.mem_wdata, 32'hCAFE);
            check("sw_vout_busy", {31'b0, valid_out}, 32'd0);
            if (i == 2) begin
                bus.mem_ack = 1'b1;
                idle();
                #1 check("sw_stall_ack", {31'b0, STALL_M}, 32'd0);
            end else begin
                check("sw_stall_busy", {31'b0, STALL_M}, 32'd1);
            end
            tick();
        end
        bus.mem_ack = 1'b0;
        check("sw_done_req",  {31'b0, bus.mem_req}, 32'd0);
        check("sw_done_vout", {31'b0, valid_out}, 32'd1);
        check("sw_done_rw",   {31'b0, RegWriteW}, 32'd0);
        check("sw_done_m2r",  {31'b0, MemtoRegW}, 32'd0);

        // clear any bypass entry so the lw below always goes to memory
        RESET = 1'b1;
        tick();
        RESET = 1'b0;

        // lw 0x10, ack in the second busy cycle
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h10, 32'h0);
        tick();
        idle();
        check("lw_req",  {31'b0, bus.mem_req}, 32'd1);
        check("lw_we",   {31'b0, bus.mem_we}, 32'd0);
        check("lw_addr", {20'b0, bus.mem_addr}, 32'd4);
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        check("lw_rdw",  ReadDataW, 32'hCAFE);
        check("lw_m2r",  {31'b0, MemtoRegW}, 32'd1);
        check("lw_rw",   {31'b0, RegWriteW}, 32'd1);
        check("lw_wreg", {27'b0, WriteRegW}, 32'd9);
        check("lw_aluw", ALUOutW, 32'h10);
        check("lw_vout", {31'b0, valid_out}, 32'd1);
        check("lw_req_off", {31'b0, bus.mem_req}, 32'd0);
        tick();
        check("lw_vout_once", {31'b0, valid_out}, 32'd0);

        // misaligned lw 0x13
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 32'h13, 32'h0);
        #1 check("mis_stall", {31'b0, STALL_M}, 32'd0);
        tick();
        idle();
        check("mis_req",  {31'b0, bus.mem_req}, 32'd0);
        check("mis_aerr", {31'b0, align_err}, 32'd1);
        check("mis_rw",   {31'b0, RegWriteW}, 32'd0);
        check("mis_vout", {31'b0, valid_out}, 32'd1);
        check("mis_m2r",  {31'b0, MemtoRegW}, 32'd0);

        // lw 0x40 never acknowledged: timeout after 4 busy cycles
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h40, 32'h0);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            check("to_req",   {31'b0, bus.mem_req}, 32'd1);
            check("to_stall", {31'b0, STALL_M}, 32'd1);
            check("to_berr_pending", {31'b0, bus_err}, 32'd0);
            tick();
        end
        check("to_req_off", {31'b0, bus.mem_req}, 32'd0);
        check("to_berr",    {31'b0, bus_err}, 32'd1);
        check("to_vout",    {31'b0, valid_out}, 32'd1);
        check("to_rw",      {31'b0, RegWriteW}, 32'd0);
        check("to_m2r",     {31'b0, MemtoRegW}, 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD;
        #1 check("late_stall", {31'b0, STALL_M}, 32'd0);
        tick();
        bus.mem_ack   = 1'b0;
        check("late_rdw",  ReadDataW, 32'hCAFE);
        check("late_vout", {31'b0, valid_out}, 32'd0);
        check("late_req",  {31'b0, bus.mem_req}, 32'd0);
        check("late_berr", {31'b0, bus_err}, 32'd1);
        check("late_aerr", {31'b0, align_err}, 32'd1);

        // reset while busy aborts the access
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h20, 32'h1234);
        tick();
        idle();
        check("rb_req_busy", {31'b0, bus.mem_req}, 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("rb_req",   {31'b0, bus.mem_req}, 32'd0);
        check("rb_stall", {31'b0, STALL_M}, 32'd0);
        check("rb_addr",  {20'b0, bus.mem_addr}, 32'd0);
        check("rb_wdata", bus.mem_wdata, 32'd0);
        check("rb_errs",  {30'b0, align_err, bus_err}, 32'd0);
        check("rb_rdw",   ReadDataW, 32'd0);
        check("rb_vout",  {31'b0, valid_out}, 32'd0);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("rb_ack_vout", {31'b0, valid_out}, 32'd0);
        check("rb_ack_req",  {31'b0, bus.mem_req}, 32'd0);

        // sw 0x20 then lw 0x20: served from the store buffer when the bypass is built in
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h20, 32'h1234);
        tick();
        idle();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("bp_sw_vout", {31'b0, valid_out}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 32'h20, 32'h0);
        #1 check("bp_stall", {31'b0, STALL_M}, {31'b0, ~BYP});
        tick();
        idle();
        check("bp_req",  {31'b0, bus.mem_req}, {31'b0, ~BYP});
        check("bp_vout", {31'b0, valid_out}, {31'b0, BYP});
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD1;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        check("bp_rdw", ReadDataW, BYP ? 32'h1234 : 32'hBAD1);
        check("bp_req_off", {31'b0, bus.mem_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
